// File: rtl/pong_renderer.sv
// Two-stage Pong pixel renderer: paddles, ball, border and background with a goal flash.
// Optional dashed centre net is enabled by defining PONG_CENTER_LINE_EN.
module pong_renderer #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int COORD_W      = 10,
    parameter int COLOR_W      = 4,
    parameter int PADDLE_HW    = 5,
    parameter int PADDLE_HH    = 25,
    parameter int BALL_HW      = 5,
    parameter int BALL_HH      = 5,
    parameter int PADDLE1X     = 20,
    parameter int PADDLE2X     = 620,
    parameter int FLASH_FRAMES = 30
) (
    input  logic               VGA_CLOCK,
    input  logic               RESET,
    input  logic [COORD_W-1:0] XPOS,
    input  logic [COORD_W-1:0] YPOS,
    input  logic               DISP_EN,
    input  logic [COORD_W-1:0] PADDLE1Y,
    input  logic [COORD_W-1:0] PADDLE2Y,
    input  logic [COORD_W-1:0] BALLX,
    input  logic [COORD_W-1:0] BALLY,
    input  logic               GOAL,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               FLASH_ACTIVE
);

    localparam int SW    = COORD_W + 2;
    localparam int CNT_W = ($clog2(FLASH_FRAMES + 1) > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
    localparam logic [COLOR_W-1:0] CMAX = {COLOR_W{1'b1}};

    // Distance is taken in two extra signed bits so objects at the screen edges never wrap.
    function automatic logic near(input logic [COORD_W-1:0] p,
                                  input logic [COORD_W-1:0] c,
                                  input int h);
        logic signed [SW-1:0] d;
        d = $signed({2'b00, p}) - $signed({2'b00, c});
        if (d < 0) d = -d;
        return d < $signed(SW'(h));
    endfunction

    logic               cap;
    logic [COORD_W-1:0] sh_p1y, sh_p2y, sh_bx, sh_by;
    logic [CNT_W-1:0]   flash_cnt;

    assign cap = (XPOS == '0) && (YPOS == COORD_W'(V_ACTIVE));

    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            sh_p1y <= COORD_W'(V_ACTIVE / 2);
            sh_p2y <= COORD_W'(V_ACTIVE / 2);
            sh_bx  <= COORD_W'(H_ACTIVE / 2);
            sh_by  <= COORD_W'(V_ACTIVE / 2);
        end else if (cap) begin
            sh_p1y <= PADDLE1Y;
            sh_p2y <= PADDLE2Y;
            sh_bx  <= BALLX;
            sh_by  <= BALLY;
        end
    end

    // A goal always (re)loads the counter, even when it coincides with a capture.
    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            flash_cnt    <= '0;
            FLASH_ACTIVE <= 1'b0;
        end else if (GOAL) begin
            flash_cnt    <= CNT_W'(FLASH_FRAMES);
            FLASH_ACTIVE <= (CNT_W'(FLASH_FRAMES) != '0);
        end else if (cap && (flash_cnt != '0)) begin
            flash_cnt    <= flash_cnt - CNT_W'(1);
            FLASH_ACTIVE <= (flash_cnt != CNT_W'(1));
        end
    end

    logic s1_p1, s1_p2, s1_ball, s1_border, s1_en;
`ifdef PONG_CENTER_LINE_EN
    logic s1_net;
`endif

    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            s1_p1     <= 1'b0;
            s1_p2     <= 1'b0;
            s1_ball   <= 1'b0;
            s1_border <= 1'b0;
            s1_en     <= 1'b0;
`ifdef PONG_CENTER_LINE_EN
            s1_net    <= 1'b0;
`endif
        end else begin
            s1_p1     <= near(XPOS, COORD_W'(PADDLE1X), PADDLE_HW) && near(YPOS, sh_p1y, PADDLE_HH);
            s1_p2     <= near(XPOS, COORD_W'(PADDLE2X), PADDLE_HW) && near(YPOS, sh_p2y, PADDLE_HH);
            s1_ball   <= near(XPOS, sh_bx, BALL_HW) && near(YPOS, sh_by, BALL_HH);
            s1_border <= (XPOS == '0) || (XPOS == COORD_W'(H_ACTIVE - 1)) ||
                         (YPOS == '0) || (YPOS == COORD_W'(V_ACTIVE - 1));
            s1_en     <= DISP_EN;
`ifdef PONG_CENTER_LINE_EN
            s1_net    <= ((XPOS == COORD_W'(H_ACTIVE / 2 - 1)) || (XPOS == COORD_W'(H_ACTIVE / 2)))
                         && !YPOS[3];
`endif
        end
    end

    logic fg;

    always_comb begin
        fg = s1_p1 | s1_p2 | s1_ball | s1_border;
`ifdef PONG_CENTER_LINE_EN
        fg = fg | s1_net;
`endif
    end

    // Background colour follows the live flash state, not the state when the pixel entered.
    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            R <= '0;
            G <= '0;
            B <= '0;
        end else if (!s1_en) begin
            R <= '0;
            G <= '0;
            B <= '0;
        end else if (fg) begin
            R <= CMAX;
            G <= CMAX;
            B <= CMAX;
        end else if (FLASH_ACTIVE) begin
            R <= CMAX;
            G <= '0;
            B <= '0;
        end else begin
            R <= '0;
            G <= '0;
            B <= CMAX;
        end
    end

endmodule

// File: doc/pong_renderer.md
# pong_renderer

Parametrised, pipelined pixel renderer for the Pong VGA datapath. It sits between the VGA timing generator (XPOS/YPOS/DISP_EN) and the DAC pins. It draws two paddles, the ball, the screen border and the background at configurable colour depth. Object positions are captured once per frame into shadow registers so the picture never tears. A goal pulse flashes the background red for a programmable number of frames.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- COORD_W, 10, width of all coordinate ports
- COLOR_W, 4, bits per colour channel
- PADDLE_HW, 5, paddle half-width
- PADDLE_HH, 25, paddle half-height
- BALL_HW, 5, ball half-width
- BALL_HH, 5, ball half-height
- PADDLE1X, 20, paddle 1 centre X
- PADDLE2X, 620, paddle 2 centre X
- FLASH_FRAMES, 30, frames of red background after GOAL

Ports:
- VGA_CLOCK  in  1  pixel clock. One clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset
- XPOS, YPOS  in  COORD_W  current pixel coordinate from timing generator (unsigned)
- DISP_EN  in  1  high during active video
- PADDLE1Y, PADDLE2Y, BALLX, BALLY  in  COORD_W  live object centres from game logic
- GOAL  in  1  single-cycle pulse on score
- R, G, B  out  COLOR_W each  pixel colour
- FLASH_ACTIVE  out  1  high while flash counter nonzero

## Operation
- Capture event (CAP): cycle with XPOS==0 && YPOS==V_ACTIVE, i.e. the first blanking line. On CAP, PADDLE1Y, PADDLE2Y, BALLX and BALLY are copied into shadow registers. Rendering uses only the shadow values.
- Shadow reset values: PADDLE1Y = PADDLE2Y = V_ACTIVE/2; BALLX = H_ACTIVE/2; BALLY = V_ACTIVE/2.
- Hit tests use strict inequality: |X − cx| < hw and |Y − cy| < hh. Compare as signed COORD_W+2 bits so that objects near 0 or the max coordinate do not wrap.
- Priority, highest first:
  - paddle1, paddle2, ball: white (all ones)
  - border (X==0, X==H_ACTIVE−1, Y==0, Y==V_ACTIVE−1): white
  - net (if configured, see Configuration): white
  - background: blue {0,0,max}, or red {max,0,0} while FLASH_ACTIVE
- Output is black (all channels 0) whenever delayed DISP_EN is low.
- Flash counter, width ≥ clog2(FLASH_FRAMES+1):
  - GOAL loads FLASH_FRAMES, including when the counter is already nonzero (restart).
  - Each CAP decrements the counter if it is nonzero.
  - GOAL and CAP in the same cycle: the load wins.
  - FLASH_ACTIVE = (counter != 0). It is registered together with the counter.

## Timing
- 2-stage pipeline:
  - Stage 1 registers the hit flags, the border flag, the net flag and DISP_EN.
  - Stage 2 registers R/G/B.
  - Latency from XPOS/YPOS/DISP_EN to R/G/B is exactly 2 cycles, throughput 1 pixel/cycle.
- The shadow update on CAP takes effect for pixels entering stage 1 on the cycle after CAP.
- The flash background colour is sampled in stage 2 from the current FLASH_ACTIVE.
- Reset values: R=G=B=0, FLASH_ACTIVE=0, counter 0, all pipeline registers 0, shadows at their reset values.
- Reset asserted mid-frame: outputs go to 0 immediately. After release, outputs are black until a DISP_EN-high pixel has passed both stages (≥2 cycles). Rendering resumes with the reset shadow positions until the next CAP.

## Configuration
- PONG_CENTER_LINE_EN defined: a dashed net is drawn at X ∈ {H_ACTIVE/2−1, H_ACTIVE/2} on lines where YPOS[3]==0 (8 lines on, 8 off), with priority below border and above background.
- Undefined: no net logic is generated; those pixels show background.

## Test plan
- Reset, DISP_EN=1 at (320,240) → R,G,B = 0 during reset. Two cycles after release, pixel (10,10) gives {0,0,15} and (20,240) gives white (paddle1 at reset shadow Y=240).
- PADDLE1Y=100, then CAP → (20,100) and (24,124) are white, (25,100) and (20,125) are blue, each with 2-cycle latency. Changing PADDLE1Y mid-frame does not affect output until the next CAP.
- BALLX=3, BALLY=3 after CAP → (0,0)–(7,7) white with no wrap artefacts; (639,479) is white via the border.
- GOAL pulse → FLASH_ACTIVE=1 next cycle and background {15,0,0} for exactly 30 CAPs. A second GOAL at the 10th CAP restarts the count to 30. GOAL coincident with CAP loads 30.
- DISP_EN low at any pixel → that pixel output 0 two cycles later, even on a paddle or border.
- With PONG_CENTER_LINE_EN: (319,0..7) white, (320,8) blue, (319,16) white. Without it: (319,5) blue.
